fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch front end: a word-addressed instruction memory feeding a
// small circular queue of {PC, instruction} entries toward decode.
module fetch_queue #(
   parameter int               XLEN       = 32,
   parameter int               IMEM_DEPTH = 256,
   parameter int               QDEPTH     = 4,
   parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
   input  logic                             CLK,
   input  logic                             RST,
   input  logic                             WE,
   input  logic [XLEN-1:0]                  W_Addr,
   input  logic [31:0]                      W_Ins,
   input  logic                             Redirect,
   input  logic [XLEN-1:0]                  RedirectPC,
   input  logic                             Out_Ready,
   output logic                             Out_Valid,
   output logic [31:0]                      Out_Ins,
   output logic [XLEN-1:0]                  Out_PC,
   output logic [XLEN-1:0]                  Out_NextPC,
   output logic [XLEN-1:0]                  PC,
   output logic [$clog2(QDEPTH+1)-1:0]      Count
);

   localparam int AW = $clog2(IMEM_DEPTH);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH+1);

   localparam logic [CW-1:0]   QDEPTH_C = CW'(QDEPTH);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
   localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
   localparam logic [PW-1:0]   PTR_ZERO = PW'(0);
   localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

   logic [31:0]     imem_r  [IMEM_DEPTH];
   logic [31:0]     ins_q_r [QDEPTH];
   logic [XLEN-1:0] pc_q_r  [QDEPTH];
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [CW-1:0]   count_r;
   logic [XLEN-1:0] pc_r;

   logic            valid_s;
   logic            pop_s;
   logic            push_s;
   logic [31:0]     fetch_ins_s;
   logic            unused_s;

   assign valid_s     = (count_r != CNT_ZERO);
   assign pop_s       = valid_s & Out_Ready & ~Redirect;
   // A full queue still accepts a fetch when the head leaves in the same cycle.
   assign push_s      = ~Redirect & ((count_r < QDEPTH_C) | pop_s);
   assign fetch_ins_s = imem_r[pc_r[AW+1:2]];

   assign unused_s    = ^{W_Addr[XLEN-1:AW+2], W_Addr[1:0], RedirectPC[1:0]};

   // Instruction memory write port; contents survive reset.
   always_ff @(posedge CLK) begin
      if (WE) begin
         imem_r[W_Addr[AW+1:2]] <= W_Ins;
      end
   end

   // Queue payload storage, written at the tail on every push.
   always_ff @(posedge CLK) begin
      if (push_s) begin
         ins_q_r[tail_r] <= fetch_ins_s;
         pc_q_r[tail_r]  <= pc_r;
      end
   end

   // Fetch PC, queue pointers and occupancy; redirect overrides push and pop.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         pc_r    <= RESET_PC;
         head_r  <= PTR_ZERO;
         tail_r  <= PTR_ZERO;
         count_r <= CNT_ZERO;
      end else if (Redirect) begin
         pc_r    <= {RedirectPC[XLEN-1:2], 2'b00};
         head_r  <= PTR_ZERO;
         tail_r  <= PTR_ZERO;
         count_r <= CNT_ZERO;
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PTR_ONE;
            pc_r   <= pc_r + PC_STEP;
         end
         if (pop_s) begin
            head_r <= head_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign Out_Valid  = valid_s;
   assign Out_Ins    = ins_q_r[head_r];
   assign Out_PC     = pc_q_r[head_r];
   assign Out_NextPC = pc_q_r[head_r] + PC_STEP;
   assign PC         = pc_r;
   assign Count      = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a reference queue model predicts every
// fetched entry and checks it when it reaches the head.
module tb_fetch_queue;

   logic        CLK;
   logic        RST;
   logic        WE;
   logic [31:0] W_Addr;
   logic [31:0] W_Ins;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic        Out_Ready;
   logic        Out_Valid;
   logic [31:0] Out_Ins;
   logic [31:0] Out_PC;
   logic [31:0] Out_NextPC;
   logic [31:0] PC;
   logic [2:0]  Count;

   int          n_pass;
   int          n_total;

   logic [31:0] mem_m [256];
   logic [63:0] exp_q [$];
   int          cnt_m;
   logic [31:0] pc_m;

   fetch_queue #(
      .XLEN(32), .IMEM_DEPTH(256), .QDEPTH(4), .RESET_PC(32'h0)
   ) dut (
      .CLK(CLK), .RST(RST), .WE(WE), .W_Addr(W_Addr), .W_Ins(W_Ins),
      .Redirect(Redirect), .RedirectPC(RedirectPC), .Out_Ready(Out_Ready),
      .Out_Valid(Out_Valid), .Out_Ins(Out_Ins), .Out_PC(Out_PC),
      .Out_NextPC(Out_NextPC), .PC(PC), .Count(Count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle: drive at negedge, compare pre-edge outputs, advance model.
   task automatic step(input logic rdy, input logic rdr, input logic [31:0] rpc,
                       input logic we, input logic [31:0] wa, input logic [31:0] wi);
      logic [63:0] head;
      logic        pop_m;
      logic        push_m;
      @(negedge CLK);
      Out_Ready  = rdy;
      Redirect   = rdr;
      RedirectPC = rpc;
      WE         = we;
      W_Addr     = wa;
      W_Ins      = wi;
      #1;
      check("count", {61'd0, Count}, 64'(cnt_m));
      check("pc", {32'd0, PC}, {32'd0, pc_m});
      check("valid", {63'd0, Out_Valid}, {63'd0, (cnt_m != 0)});
      if (cnt_m != 0) begin
         head = exp_q[0];
         check("out_pc", {32'd0, Out_PC}, {32'd0, head[63:32]});
         check("out_ins", {32'd0, Out_Ins}, {32'd0, head[31:0]});
         check("out_nextpc", {32'd0, Out_NextPC}, {32'd0, head[63:32] + 32'd4});
      end
      pop_m  = (cnt_m != 0) && rdy && !rdr;
      push_m = !rdr && ((cnt_m < 4) || pop_m);
      if (rdr) begin
         exp_q.delete();
         cnt_m = 0;
         pc_m  = {rpc[31:2], 2'b00};
      end else begin
         if (pop_m) void'(exp_q.pop_front());
         if (push_m) begin
            exp_q.push_back({pc_m, mem_m[pc_m[9:2]]});
            pc_m = pc_m + 32'd4;
         end
         cnt_m = cnt_m + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      end
      if (we) mem_m[wa[9:2]] = wi;
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge CLK);
      WE     = 1'b1;
      W_Addr = a;
      W_Ins  = d;
      @(posedge CLK);
      #1;
      WE = 1'b0;
      mem_m[a[9:2]] = d;
   endtask

   // Asynchronous reset pulse in the middle of the low clock phase.
   task automatic do_reset(input string tag);
      @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      check({tag, "_valid"}, {63'd0, Out_Valid}, 64'd0);
      check({tag, "_count"}, {61'd0, Count}, 64'd0);
      check({tag, "_pc"}, {32'd0, PC}, 64'd0);
      @(posedge CLK);
      #1;
      RST   = 1'b1;
      cnt_m = 0;
      pc_m  = 32'd0;
      exp_q.delete();
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      RST = 1'b0;
      WE = 1'b0;
      W_Addr = 32'd0;
      W_Ins = 32'd0;
      Redirect = 1'b0;
      RedirectPC = 32'd0;
      Out_Ready = 1'b0;
      #1;
      check("rst_valid", {63'd0, Out_Valid}, 64'd0);
      check("rst_count", {61'd0, Count}, 64'd0);
      check("rst_pc", {32'd0, PC}, 64'd0);

      for (int i = 0; i < 256; i++)
         wr(32'(i * 4), (i < 4) ? 32'(32'h11 * (i + 1)) : 32'h1000_0000 + 32'(i));
      check("rst_hold_count", {61'd0, Count}, 64'd0);
      RST = 1'b1;
      cnt_m = 0;
      pc_m = 32'd0;
      exp_q.delete();

      // Streaming from reset with decode always ready.
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
         check("stream_ins", {32'd0, Out_Ins}, 64'(32'h11 * (k + 1)));
         check("stream_pc", {32'd0, Out_PC}, 64'(4 * k));
      end
      repeat (2) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

      // Stall after reset: queue fills and saturates, then drains in order.
      do_reset("midrst");
      repeat (6) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      check("sat_count", {61'd0, Count}, 64'd4);
      check("sat_pc", {32'd0, PC}, 64'd16);
      check("sat_head", {32'd0, Out_Ins}, 64'h11);
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
         check("full_flow_count", {61'd0, Count}, 64'd4);
      end

      // Redirect with three entries queued flushes them.
      step(1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
      repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      check("pre_redir_count", {61'd0, Count}, 64'd3);
      step(1'b1, 1'b1, 32'h42, 1'b0, 32'd0, 32'd0);
      check("redir_count", {61'd0, Count}, 64'd0);
      check("redir_valid", {63'd0, Out_Valid}, 64'd0);
      check("redir_pc", {32'd0, PC}, 64'h40);
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      check("redir_head_pc", {32'd0, Out_PC}, 64'h40);
      repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

      // Write and fetch of the same word in one cycle: old word queued.
      step(1'b0, 1'b1, 32'h80, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 32'hDEAD_BEEF);
      check("wr_same_old", {32'd0, Out_Ins}, 64'h1000_0020);
      step(1'b0, 1'b1, 32'h80, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      check("wr_refetch_new", {32'd0, Out_Ins}, 64'hDEAD_BEEF);

      // Asynchronous reset with two entries queued.
      step(1'b0, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0);
      repeat (2) step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      check("pre_rst_count", {61'd0, Count}, 64'd2);
      do_reset("async");
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
         check("restart_ins", {32'd0, Out_Ins}, 64'(32'h11 * (k + 1)));
      end
      step(1'b1, 1'b1, 32'h80, 1'b0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
      check("mem_kept", {32'd0, Out_Ins}, 64'hDEAD_BEEF);
      repeat (2) step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
